// File: rtl/cam_cfg_scheduler.sv
// -----------------------------------------------------------------------------
// cam_cfg_scheduler
// Sequences the configuration of up to three cameras that share one config
// engine and one I2C bus mux. After a start pulse it waits for sensor
// power-up, then serves each enabled camera in ascending index order:
// settle with the engine held in reset, run a config attempt (retrying on
// error/timeout), then idle the bus for a gap before the next camera.
//
// Ports
//   clk       in   system clock, single domain
//   rst       in   synchronous active-high reset
//   start     in   one-cycle pulse, begins a sequence (ignored while busy)
//   en_mask   in   camera enables, sampled on an accepted start
//   cfg_done  in   config engine finished (level)
//   cfg_err   in   config engine error/NACK (level)
//   cfg_rst   out  active-high reset to the shared config engine
//   i2c_sel   out  shared-bus mux select
//   busy      out  sequence in progress
//   cam_ok    out  per-camera success flags
//   cam_fail  out  per-camera retries-exhausted flags
//   all_done  out  sequence finished (level)
// -----------------------------------------------------------------------------
module cam_cfg_scheduler #(
  parameter int unsigned PWR_DLY   = 3_000_000,
  parameter int unsigned SETTLE    = 16,
  parameter int unsigned GAP_DLY   = 100_000,
  parameter int unsigned TIMEOUT   = 50_000_000,
  parameter int unsigned MAX_RETRY = 2,
  parameter logic [2:0]  SEL0      = 3'b110,
  parameter logic [2:0]  SEL1      = 3'b101,
  parameter logic [2:0]  SEL2      = 3'b011,
  parameter logic [2:0]  IDLE_SEL  = 3'b111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] en_mask,
  input  logic       cfg_done,
  input  logic       cfg_err,
  output logic       cfg_rst,
  output logic [2:0] i2c_sel,
  output logic       busy,
  output logic [2:0] cam_ok,
  output logic [2:0] cam_fail,
  output logic       all_done
);

  // One shared cycle counter, wide enough for the longest state duration.
  localparam int unsigned MAX_PS = (PWR_DLY > SETTLE) ? PWR_DLY : SETTLE;
  localparam int unsigned MAX_GT = (GAP_DLY > TIMEOUT) ? GAP_DLY : TIMEOUT;
  localparam int unsigned MAX_D  = (MAX_PS > MAX_GT) ? MAX_PS : MAX_GT;
  localparam int unsigned CW     = $clog2(MAX_D + 32'd1);
  localparam int unsigned RW     = (MAX_RETRY > 32'd0) ? $clog2(MAX_RETRY + 32'd1) : 32'd1;

  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  // Each timed state leaves on the cycle its counter reaches duration-1.
  localparam logic [CW-1:0] PWR_END    = CW'(PWR_DLY - 32'd1);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 32'd1);
  localparam logic [CW-1:0] GAP_END    = CW'(GAP_DLY - 32'd1);
  localparam logic [CW-1:0] TMO_END    = CW'(TIMEOUT - 32'd1);
  localparam logic [RW-1:0] RETRY_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] RETRY_ONE  = RW'(1'b1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_SELECT   = 3'd2,
    ST_CONFIG   = 3'd3,
    ST_GAP      = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Lowest enabled camera with index >= lo; result is {found, index}.
  function automatic logic [2:0] pick_cam(input logic [2:0] mask, input logic [2:0] lo);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (i >= int'(lo))) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  function automatic logic [2:0] sel_of(input logic [1:0] cam);
    logic [2:0] sel;
    case (cam)
      2'd0:    sel = SEL0;
      2'd1:    sel = SEL1;
      2'd2:    sel = SEL2;
      default: sel = IDLE_SEL;
    endcase
    return sel;
  endfunction

  state_t        state_r, state_s;
  logic [1:0]    cam_r, cam_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [RW-1:0] retry_r, retry_s;
  logic [2:0]    mask_r, mask_s;
  logic [2:0]    ok_r, ok_s;
  logic [2:0]    fail_r, fail_s;
  logic          fail_ev_s;
  logic [2:0]    first_pick_s;
  logic [2:0]    next_pick_s;

  logic          cfg_rst_r, cfg_rst_s;
  logic [2:0]    sel_r, sel_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;

  assign first_pick_s = pick_cam(mask_r, 3'b000);
  assign next_pick_s  = pick_cam(mask_r, {1'b0, cam_r} + 3'b001);

  // Next-state, counter, retry and result-flag logic.
  always_comb begin
    state_s   = state_r;
    cam_s     = cam_r;
    cnt_s     = cnt_r;
    retry_s   = retry_r;
    mask_s    = mask_r;
    ok_s      = ok_r;
    fail_s    = fail_r;
    fail_ev_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_s   = CNT_ZERO;
          retry_s = RETRY_ZERO;
          ok_s    = 3'b000;
          fail_s  = 3'b000;
          if (en_mask != 3'b000) begin
            mask_s  = en_mask;
            state_s = ST_PWR_WAIT;
          end else begin
            mask_s  = 3'b000;
            state_s = ST_DONE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_PWR_WAIT: begin
        if (cnt_r == PWR_END) begin
          cam_s   = first_pick_s[1:0];
          cnt_s   = CNT_ZERO;
          state_s = ST_SELECT;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_SELECT: begin
        if (cnt_r == SETTLE_END) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_CONFIG;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_CONFIG: begin
        // Engine status is stale on the first cycle out of reset, so cnt 0
        // never evaluates it. Error outranks done; timeout comes last.
        if ((cnt_r != CNT_ZERO) && cfg_err) begin
          fail_ev_s = 1'b1;
        end else if ((cnt_r != CNT_ZERO) && cfg_done) begin
          ok_s[cam_r] = 1'b1;
          retry_s     = RETRY_ZERO;
          cnt_s       = CNT_ZERO;
          state_s     = ST_GAP;
        end else if (cnt_r == TMO_END) begin
          fail_ev_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
        if (fail_ev_s) begin
          cnt_s = CNT_ZERO;
          if (retry_r < RETRY_MAX) begin
            retry_s = retry_r + RETRY_ONE;
            state_s = ST_SELECT;
          end else begin
            fail_s[cam_r] = 1'b1;
            retry_s       = RETRY_ZERO;
            state_s       = ST_GAP;
          end
        end else begin
          fail_ev_s = 1'b0;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_END) begin
          cnt_s = CNT_ZERO;
          if (next_pick_s[2]) begin
            cam_s   = next_pick_s[1:0];
            state_s = ST_SELECT;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with state entry.
  always_comb begin
    cfg_rst_s = 1'b1;
    sel_s     = IDLE_SEL;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_PWR_WAIT: begin
        busy_s = 1'b1;
      end
      ST_SELECT: begin
        busy_s = 1'b1;
        sel_s  = sel_of(cam_s);
      end
      ST_CONFIG: begin
        busy_s    = 1'b1;
        cfg_rst_s = 1'b0;
        sel_s     = sel_of(cam_s);
      end
      ST_GAP: begin
        busy_s = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cam_r     <= 2'd0;
      cnt_r     <= CNT_ZERO;
      retry_r   <= RETRY_ZERO;
      mask_r    <= 3'b000;
      ok_r      <= 3'b000;
      fail_r    <= 3'b000;
      cfg_rst_r <= 1'b1;
      sel_r     <= IDLE_SEL;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cam_r     <= cam_s;
      cnt_r     <= cnt_s;
      retry_r   <= retry_s;
      mask_r    <= mask_s;
      ok_r      <= ok_s;
      fail_r    <= fail_s;
      cfg_rst_r <= cfg_rst_s;
      sel_r     <= sel_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign cfg_rst  = cfg_rst_r;
  assign i2c_sel  = sel_r;
  assign busy     = busy_r;
  assign cam_ok   = ok_r;
  assign cam_fail = fail_r;
  assign all_done = done_r;

endmodule

// File: tb/tb_cam_cfg_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cam_cfg_scheduler
// Self-checking bench for cam_cfg_scheduler with short delays. A reactive
// config-engine model answers each CONFIG attempt from a per-camera,
// per-attempt response table; an independent model expands the same table
// into the expected cycle-by-cycle output trace.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cam_cfg_scheduler;

  localparam int PWR_DLY   = 10;
  localparam int SETTLE    = 4;
  localparam int GAP_DLY   = 5;
  localparam int TIMEOUT   = 100;
  localparam int MAX_RETRY = 1;
  localparam int NATT      = MAX_RETRY + 1;

  // Response kinds: 0 done at k, 1 err at k, 2 silent, 3 done+err at k.
  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_NONE = 2;
  localparam int K_BOTH = 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] en_mask;
  logic       cfg_done;
  logic       cfg_err;
  logic       cfg_rst;
  logic [2:0] i2c_sel;
  logic       busy;
  logic [2:0] cam_ok;
  logic [2:0] cam_fail;
  logic       all_done;

  int tests_run;
  int tests_failed;

  int kind_a [3][NATT];
  int k_a    [3][NATT];
  logic [13:0] exp_q [$];

  cam_cfg_scheduler #(
    .PWR_DLY  (PWR_DLY),
    .SETTLE   (SETTLE),
    .GAP_DLY  (GAP_DLY),
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .en_mask (en_mask),
    .cfg_done(cfg_done),
    .cfg_err (cfg_err),
    .cfg_rst (cfg_rst),
    .i2c_sel (i2c_sel),
    .busy    (busy),
    .cam_ok  (cam_ok),
    .cam_fail(cam_fail),
    .all_done(all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] sel_code(input int c);
    case (c)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  function automatic int cam_of(input logic [2:0] s);
    case (s)
      3'b101:  return 1;
      3'b011:  return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [13:0] pack(input logic [2:0] ok, input logic [2:0] fl,
                                       input logic ad, input logic b, input logic r,
                                       input logic [2:0] s);
    return {ok, fl, ad, b, r, s};
  endfunction

  function automatic logic [13:0] observed();
    return pack(cam_ok, cam_fail, all_done, busy, cfg_rst, i2c_sel);
  endfunction

  // Expected trace, starting on the first cycle after the accepted start.
  task automatic build_trace(input logic [2:0] mask);
    logic [2:0] ok;
    logic [2:0] fl;
    int len;
    bit good;
    exp_q.delete();
    ok = 3'b000;
    fl = 3'b000;
    repeat (PWR_DLY) exp_q.push_back(pack(ok, fl, 1'b0, 1'b1, 1'b1, 3'b111));
    for (int c = 0; c < 3; c++) begin
      if (mask[c]) begin
        for (int a = 0; a < NATT; a++) begin
          repeat (SETTLE) exp_q.push_back(pack(ok, fl, 1'b0, 1'b1, 1'b1, sel_code(c)));
          if (kind_a[c][a] == K_NONE) begin
            len  = TIMEOUT;
            good = 1'b0;
          end else begin
            len  = ((k_a[c][a] < 1) ? 1 : k_a[c][a]) + 1;
            good = (kind_a[c][a] == K_DONE);
          end
          repeat (len) exp_q.push_back(pack(ok, fl, 1'b0, 1'b1, 1'b0, sel_code(c)));
          if (good) begin
            ok[c] = 1'b1;
            break;
          end else if (a == MAX_RETRY) begin
            fl[c] = 1'b1;
          end
        end
        repeat (GAP_DLY) exp_q.push_back(pack(ok, fl, 1'b0, 1'b1, 1'b1, 3'b111));
      end
    end
    repeat (4) exp_q.push_back(pack(ok, fl, 1'b1, 1'b0, 1'b1, 3'b111));
  endtask

  // Runs one sequence from IDLE/DONE, acting as the config engine and
  // comparing every cycle against the model. Entered and left at posedge+1.
  task automatic run_seq(input logic [2:0] mask, input bit poke_start);
    int att [3];
    int cur;
    int cur_att;
    int c;
    int kd;
    int kk;
    int nerr;
    bit prev_rst;
    logic [13:0] got;
    build_trace(mask);
    att = '{0, 0, 0};
    cur = 0; cur_att = 0; c = 0; nerr = 0; prev_rst = 1'b1;
    start = 1'b1;
    en_mask = mask;
    @(posedge clk); #1;
    start = 1'b0;
    en_mask = 3'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = observed();
      tests_run++;
      if (got !== exp_q[i]) begin
        tests_failed++;
        nerr++;
        if (nerr <= 4)
          $display("FAIL trace mask=%b cyc=%0d got ok/fail/done/busy/rst/sel=%b want %b",
                   mask, i, got, exp_q[i]);
      end
      if (!cfg_rst) begin
        if (prev_rst) begin
          cur = cam_of(i2c_sel);
          cur_att = (att[cur] < NATT) ? att[cur] : NATT - 1;
          att[cur]++;
          c = 0;
        end else begin
          c++;
        end
        kd = kind_a[cur][cur_att];
        kk = k_a[cur][cur_att];
        cfg_done = ((kd == K_DONE) || (kd == K_BOTH)) && (c >= kk);
        cfg_err  = ((kd == K_ERR)  || (kd == K_BOTH)) && (c >= kk);
      end else begin
        cfg_done = 1'b0;
        cfg_err  = 1'b0;
      end
      prev_rst = cfg_rst;
      if (poke_start && (i == 3)) begin
        start = 1'b1;
        en_mask = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    cfg_done = 1'b0;
    cfg_err  = 1'b0;
    start    = 1'b0;
  endtask

  task automatic set_all(input int kd, input int kk);
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < NATT; a++) begin
        kind_a[c][a] = kd;
        k_a[c][a]    = kk;
      end
  endtask

  task automatic check_flags(input string name, input logic [2:0] ok, input logic [2:0] fl);
    tests_run++;
    if ((cam_ok !== ok) || (cam_fail !== fl)) begin
      tests_failed++;
      $display("FAIL %s got cam_ok=%b cam_fail=%b want cam_ok=%b cam_fail=%b",
               name, cam_ok, cam_fail, ok, fl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; en_mask = 3'b000; cfg_done = 1'b0; cfg_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (observed() !== pack(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111)) begin
      tests_failed++;
      $display("FAIL reset got %b want %b", observed(),
               pack(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111));
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_all_ok();
    set_all(K_DONE, 3);
    run_seq(3'b111, 1'b0);
    check_flags("all_ok", 3'b111, 3'b000);
  endtask

  task automatic test_skip();
    set_all(K_DONE, 3);
    run_seq(3'b101, 1'b0);
    check_flags("skip_cam1", 3'b101, 3'b000);
  endtask

  task automatic test_err_retry();
    set_all(K_DONE, 3);
    kind_a[1][0] = K_ERR; k_a[1][0] = 2;
    kind_a[1][1] = K_ERR; k_a[1][1] = 0;
    run_seq(3'b111, 1'b0);
    check_flags("err_retry", 3'b101, 3'b010);
  endtask

  task automatic test_timeout_both();
    set_all(K_DONE, 3);
    kind_a[0][0] = K_NONE; kind_a[0][1] = K_NONE;
    kind_a[1][0] = K_BOTH; k_a[1][0] = 2;
    kind_a[1][1] = K_BOTH; k_a[1][1] = 1;
    run_seq(3'b111, 1'b0);
    check_flags("timeout_both", 3'b100, 3'b011);
  endtask

  task automatic test_start_ignored();
    set_all(K_DONE, 1);
    kind_a[2][0] = K_ERR; k_a[2][0] = 4;
    run_seq(3'b110, 1'b1);
    check_flags("start_ignored", 3'b110, 3'b000);
  endtask

  task automatic test_zero_mask();
    start = 1'b1; en_mask = 3'b000;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (observed() !== pack(3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 3'b111)) begin
      tests_failed++;
      $display("FAIL zero_mask got %b want %b", observed(),
               pack(3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 3'b111));
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (observed() !== pack(3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 3'b111)) begin
      tests_failed++;
      $display("FAIL zero_mask_hold got %b want %b", observed(),
               pack(3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 3'b111));
    end
  endtask

  task automatic test_rst_mid();
    bool_wait: begin end
    start = 1'b1; en_mask = 3'b111;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if ((i2c_sel == 3'b101) && !cfg_rst) break;
      cfg_done = (i2c_sel == 3'b110) && !cfg_rst;
      @(posedge clk); #1;
    end
    cfg_done = 1'b0;
    tests_run++;
    if ((i2c_sel !== 3'b101) || (cfg_rst !== 1'b0) || (cam_ok !== 3'b001)) begin
      tests_failed++;
      $display("FAIL rst_mid_reach got sel=%b cfg_rst=%b cam_ok=%b want 101 0 001",
               i2c_sel, cfg_rst, cam_ok);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (observed() !== pack(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111)) begin
      tests_failed++;
      $display("FAIL rst_mid got %b want %b", observed(),
               pack(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111));
    end
    repeat (30) @(posedge clk);
    #1;
    tests_run++;
    if (observed() !== pack(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111)) begin
      tests_failed++;
      $display("FAIL rst_mid_idle got %b want %b", observed(),
               pack(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111));
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 24; n++) begin
      for (int c = 0; c < 3; c++)
        for (int a = 0; a < NATT; a++) begin
          r = int'($urandom_range(0, 19));
          kind_a[c][a] = (r < 12) ? K_DONE : (r < 16) ? K_ERR : (r < 19) ? K_BOTH : K_NONE;
          k_a[c][a]    = int'($urandom_range(0, 12));
        end
      run_seq(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; start = 1'b0; en_mask = 3'b000; cfg_done = 1'b0; cfg_err = 1'b0;
    test_reset();
    test_zero_mask();
    test_all_ok();
    test_zero_mask();
    test_skip();
    test_err_retry();
    test_timeout_both();
    test_start_ignored();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
